// File: rtl/dmem_pkg.sv
// Shared widths, MMIO word offsets and timer control bit positions for the
// CPU data-memory responder.
package dmem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    // MMIO word offsets relative to the MMIO base address
    localparam logic [3:0] OFF_GPIO_OUT   = 4'd0;
    localparam logic [3:0] OFF_GPIO_IN    = 4'd1;
    localparam logic [3:0] OFF_CYCLE      = 4'd2;
    localparam logic [3:0] OFF_TIMER_CMP  = 4'd3;
    localparam logic [3:0] OFF_TIMER_CTRL = 4'd4;
    localparam logic [3:0] OFF_TIMER_CNT  = 4'd5;

    // TIMER_CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_FLAG_BIT = 1;

    // True for offsets owned by the compare timer
    function automatic logic is_timer_off(input logic [3:0] off);
        return (off == OFF_TIMER_CMP) || (off == OFF_TIMER_CTRL) || (off == OFF_TIMER_CNT);
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Compare timer: counts while enabled, on CNT==CMP it restarts from 0 and
// latches a sticky flag. Interrupt is the flag qualified by the enable.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [3:0]        sel,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              timer_irq
);

    logic [DATA_W-1:0] cmp_q;
    logic [DATA_W-1:0] cnt_q;
    logic              en_q;
    logic              flag_q;

    logic wr_cmp;
    logic wr_ctrl;
    logic wr_cnt;
    logic match;

    assign wr_cmp  = wr && (sel == OFF_TIMER_CMP);
    assign wr_ctrl = wr && (sel == OFF_TIMER_CTRL);
    assign wr_cnt  = wr && (sel == OFF_TIMER_CNT);

    // Match uses the pre-write count and pre-write enable
    assign match = en_q && (cnt_q == cmp_q);

    assign timer_irq = flag_q && en_q;

    // Timer registers: a CNT write beats the count update, a match beats W1C
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_q  <= '0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            if (wr_cmp) begin
                cmp_q <= wdata;
            end
            if (wr_ctrl) begin
                en_q <= wdata[CTRL_EN_BIT];
            end
            if (match) begin
                flag_q <= 1'b1;
            end else if (wr_ctrl && wdata[CTRL_FLAG_BIT]) begin
                flag_q <= 1'b0;
            end
            if (wr_cnt) begin
                cnt_q <= wdata;
            end else if (match) begin
                cnt_q <= '0;
            end else if (en_q) begin
                cnt_q <= cnt_q + DATA_W'(1);
            end
        end
    end

    // Register read-back; CTRL bits other than en/flag read as zero
    always_comb begin
        rdata = '0;
        case (sel)
            OFF_TIMER_CMP:  rdata = cmp_q;
            OFF_TIMER_CNT:  rdata = cnt_q;
            OFF_TIMER_CTRL: begin
                rdata[CTRL_EN_BIT]   = en_q;
                rdata[CTRL_FLAG_BIT] = flag_q;
            end
            default:        rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the CPU data port: word RAM below MMIO_BASE, a 16-word MMIO
// window above it (GPIO, free-running cycle counter, compare timer).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int               READ_LATENCY = 0,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = 12'hFF0,
    parameter int               GPIO_SYNC    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] data_mem_in,
    output logic [DATA_W-1:0] data_mem_out,
    input  logic [DATA_W-1:0] gpio_in,
    output logic [DATA_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              access_err
);

    localparam int RAM_WORDS = int'(MMIO_BASE);

    logic [DATA_W-1:0] ram [0:RAM_WORDS-1];

    logic [DATA_W-1:0] gpio_out_q;
    logic [DATA_W-1:0] gpio_sync_q [GPIO_SYNC];
    logic [DATA_W-1:0] cycle_q;
    logic              err_q;
    logic              wr_ok_q;

    logic [ADDR_W-1:0] mmio_off_full;
    logic [3:0]        mmio_off;
    logic              is_ram;
    logic              is_mmio;
    logic              mmio_writable;
    logic              wr_en;
    logic              wr_ram;
    logic              wr_mmio;
    logic              wr_illegal;
    logic              wr_timer;
    logic [DATA_W-1:0] timer_rdata;
    logic [DATA_W-1:0] rd_mux;

    // Address decode
    assign is_ram        = ram_addr < MMIO_BASE;
    assign mmio_off_full = ram_addr - MMIO_BASE;
    assign is_mmio       = !is_ram && (mmio_off_full[ADDR_W-1:4] == '0);
    assign mmio_off      = mmio_off_full[3:0];
    assign mmio_writable = (mmio_off == OFF_GPIO_OUT) || is_timer_off(mmio_off);

    // wr_ok_q blocks the write on the first edge after reset release
    assign wr_en      = mem_wr && wr_ok_q;
    assign wr_ram     = wr_en && is_ram;
    assign wr_mmio    = wr_en && is_mmio && mmio_writable;
    assign wr_illegal = wr_en && !is_ram && !(is_mmio && mmio_writable);
    assign wr_timer   = wr_mmio && is_timer_off(mmio_off);

    assign gpio_out   = gpio_out_q;
    assign access_err = err_q;

    mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr_timer),
        .sel       (mmio_off),
        .wdata     (data_mem_in),
        .rdata     (timer_rdata),
        .timer_irq (timer_irq)
    );

    // RAM array; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_addr] <= data_mem_in;
        end
    end

    // Write-enable qualifier, error pulse, GPIO output and cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ok_q    <= 1'b0;
            err_q      <= 1'b0;
            gpio_out_q <= '0;
            cycle_q    <= '0;
        end else begin
            wr_ok_q <= 1'b1;
            err_q   <= wr_illegal || (mem_rd && wr_en);
            cycle_q <= cycle_q + DATA_W'(1);
            if (wr_mmio && (mmio_off == OFF_GPIO_OUT)) begin
                gpio_out_q <= data_mem_in;
            end
        end
    end

    // GPIO input synchroniser chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < GPIO_SYNC; i++) begin
                gpio_sync_q[i] <= '0;
            end
        end else begin
            gpio_sync_q[0] <= gpio_in;
            for (int i = 1; i < GPIO_SYNC; i++) begin
                gpio_sync_q[i] <= gpio_sync_q[i-1];
            end
        end
    end

    // Read mux over RAM and MMIO; unmapped words read as zero
    always_comb begin
        rd_mux = '0;
        if (is_ram) begin
            rd_mux = ram[ram_addr];
        end else if (is_mmio) begin
            case (mmio_off)
                OFF_GPIO_OUT:   rd_mux = gpio_out_q;
                OFF_GPIO_IN:    rd_mux = gpio_sync_q[GPIO_SYNC-1];
                OFF_CYCLE:      rd_mux = cycle_q;
                OFF_TIMER_CMP,
                OFF_TIMER_CTRL,
                OFF_TIMER_CNT:  rd_mux = timer_rdata;
                default:        rd_mux = '0;
            endcase
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_rd_comb
            assign data_mem_out = rd_mux;
        end else begin : g_rd_reg
            logic [DATA_W-1:0] rd_q;

            // Read register loads only on strobed reads
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_q <= '0;
                end else if (mem_rd) begin
                    rd_q <= rd_mux;
                end
            end

            assign data_mem_out = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with combinational reads and one with a
// registered read port, driven from the same stimulus.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        mem_rd;
    logic        mem_wr;
    logic [11:0] ram_addr;
    logic [31:0] data_mem_in;
    logic [31:0] gpio_in;

    logic [31:0] out0, out1;
    logic [31:0] gpio_out0, gpio_out1;
    logic        irq0, irq1;
    logic        err0, err1;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_responder #(.READ_LATENCY(0), .MMIO_BASE(12'hFF0), .GPIO_SYNC(2)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .ram_addr     (ram_addr),
        .data_mem_in  (data_mem_in),
        .data_mem_out (out0),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out0),
        .timer_irq    (irq0),
        .access_err   (err0)
    );

    data_mem_responder #(.READ_LATENCY(1), .MMIO_BASE(12'hFF0), .GPIO_SYNC(2)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .ram_addr     (ram_addr),
        .data_mem_in  (data_mem_in),
        .data_mem_out (out1),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out1),
        .timer_irq    (irq1),
        .access_err   (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        mem_wr      = 1'b1;
        ram_addr    = a;
        data_mem_in = d;
        tick();
        mem_wr      = 1'b0;
    endtask

    task automatic peek(input logic [11:0] a);
        ram_addr = a;
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        ram_addr    = 12'hFF2;
        data_mem_in = '0;
        gpio_in     = '0;

        // Reset state
        #12;
        check("rst_out0", out0, 32'h0);
        check("rst_out1", out1, 32'h0);
        check("rst_gpio_out", gpio_out0, 32'h0);
        check("rst_irq", {31'b0, irq0}, 32'h0);
        check("rst_err", {31'b0, err0}, 32'h0);
        reset = 1'b1;
        tick();

        // RAM round trip
        wr(12'h005, 32'hDEADBEEF);
        mem_rd = 1'b1;
        peek(12'h005);
        check("ram_rd_lat0", out0, 32'hDEADBEEF);
        check("ram_err_before", {31'b0, err0}, 32'h0);
        tick();
        check("ram_rd_lat1", out1, 32'hDEADBEEF);
        check("ram_err_after", {31'b0, err0}, 32'h0);
        mem_rd = 1'b0;

        // Read/write collision
        wr(12'h010, 32'h1);
        mem_rd      = 1'b1;
        mem_wr      = 1'b1;
        ram_addr    = 12'h010;
        data_mem_in = 32'h2;
        #1;
        check("coll_old_lat0", out0, 32'h1);
        tick();
        check("coll_old_lat1", out1, 32'h1);
        check("coll_err0", {31'b0, err0}, 32'h1);
        check("coll_err1", {31'b0, err1}, 32'h1);
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        tick();
        check("coll_err_clear", {31'b0, err0}, 32'h0);
        mem_rd = 1'b1;
        peek(12'h010);
        check("coll_new_lat0", out0, 32'h2);
        tick();
        check("coll_new_lat1", out1, 32'h2);
        mem_rd = 1'b0;

        // GPIO
        gpio_in = 32'hA5A5A5A5;
        peek(12'hFF1);
        check("gpio_in_sync0", out0, 32'h0);
        tick();
        check("gpio_in_sync1", out0, 32'h0);
        tick();
        check("gpio_in_sync2", out0, 32'hA5A5A5A5);
        wr(12'hFF0, 32'h12345678);
        check("gpio_out_wr", gpio_out0, 32'h12345678);
        check("gpio_out_err", {31'b0, err0}, 32'h0);
        peek(12'hFF0);
        check("gpio_out_rd", out0, 32'h12345678);
        wr(12'hFF1, 32'h0);
        check("gpio_in_wr_err", {31'b0, err0}, 32'h1);
        peek(12'hFF1);
        check("gpio_in_unchanged", out0, 32'hA5A5A5A5);
        peek(12'hFF8);
        check("unmapped_rd", out0, 32'h0);
        tick();
        check("gpio_err_clear", {31'b0, err0}, 32'h0);
        wr(12'hFF9, 32'h1);
        check("unmapped_wr_err", {31'b0, err0}, 32'h1);

        // Timer: CMP=3, enable, irq four edges later
        wr(12'hFF3, 32'h3);
        wr(12'hFF4, 32'h1);
        check("tmr_e0_irq", {31'b0, irq0}, 32'h0);
        tick();
        tick();
        tick();
        check("tmr_e3_irq", {31'b0, irq0}, 32'h0);
        tick();
        check("tmr_e4_irq", {31'b0, irq0}, 32'h1);
        peek(12'hFF5);
        check("tmr_e4_cnt", out0, 32'h0);
        wr(12'hFF4, 32'h3);
        check("tmr_w1c_irq", {31'b0, irq0}, 32'h0);
        tick();
        tick();
        peek(12'hFF5);
        check("tmr_e7_cnt", out0, 32'h3);
        wr(12'hFF4, 32'h3);
        check("tmr_set_wins_irq", {31'b0, irq0}, 32'h1);
        peek(12'hFF4);
        check("tmr_ctrl_rd", out0, 32'h3);

        // Timer wrap: CNT=FFFFFFFF, CMP=0
        wr(12'hFF4, 32'h0);
        check("wrap_dis_irq", {31'b0, irq0}, 32'h0);
        wr(12'hFF3, 32'h0);
        wr(12'hFF5, 32'hFFFFFFFF);
        peek(12'hFF5);
        check("wrap_cnt_load", out0, 32'hFFFFFFFF);
        wr(12'hFF4, 32'h3);
        check("wrap_en_irq", {31'b0, irq0}, 32'h0);
        peek(12'hFF5);
        check("wrap_cnt_hold", out0, 32'hFFFFFFFF);
        peek(12'hFF4);
        check("wrap_ctrl", out0, 32'h1);
        tick();
        peek(12'hFF5);
        check("wrap_cnt_zero", out0, 32'h0);
        check("wrap_irq_pre", {31'b0, irq0}, 32'h0);
        tick();
        check("wrap_irq_set", {31'b0, irq0}, 32'h1);
        check("wrap_cnt_stay0", out0, 32'h0);
        tick();
        check("cmp0_cnt", out0, 32'h0);
        check("cmp0_irq", {31'b0, irq0}, 32'h1);

        // Reset mid-run
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        wr(12'hFF0, 32'h000000FF);
        wr(12'hFF3, 32'h5);
        wr(12'hFF4, 32'h1);
        repeat (96) tick();
        peek(12'hFF2);
        check("mid_cycle100", out0, 32'd100);
        check("mid_gpio_ff", gpio_out0, 32'hFF);
        check("mid_irq_set", {31'b0, irq0}, 32'h1);
        mem_rd = 1'b1;
        tick();
        check("mid_lat1_cycle", out1, 32'd100);
        #3;
        reset = 1'b0;
        #1;
        check("arst_out0", out0, 32'h0);
        check("arst_out1", out1, 32'h0);
        check("arst_gpio0", gpio_out0, 32'h0);
        check("arst_gpio1", gpio_out1, 32'h0);
        check("arst_irq0", {31'b0, irq0}, 32'h0);
        check("arst_irq1", {31'b0, irq1}, 32'h0);
        check("arst_err", {31'b0, err0}, 32'h0);
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("rel_cycle0", out0, 32'h0);
        tick();
        check("rel_lat1_cycle0", out1, 32'h0);
        check("rel_cycle1", out0, 32'h1);
        mem_rd = 1'b0;
        peek(12'h005);
        check("rel_ram_kept", out0, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
